// File: rtl/ysyx_25070198_dmem_resp.sv
// ysyx_25070198_dmem_resp: data-memory responder at the slave end of the core's
// load/store port. It takes one request at a time, waits LATENCY cycles, commits
// the access against a word array and holds the response until the core takes it.
// The WAIT state always lasts LATENCY cycles, so rsp_valid rises exactly LATENCY
// edges after the accepting edge, including for LATENCY == 1.
// Optional feature: define DMEM_BACK2BACK_EN to accept a new request on the
// same edge that retires the current response.
module ysyx_25070198_dmem_resp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [29:0] BASE_WADDR = 30'h20000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [29:0] req_addr,
    input  logic [3:0]  req_mask,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wen_q, wen_d;
    logic [29:0]           addr_q, addr_d;
    logic [3:0]            mask_q, mask_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [29:0]           offset_c;
    logic                  in_range_c;
    logic [DEPTH_LOG2-1:0] idx_c;
    logic                  mem_we_c;
    logic                  accept_c;

    logic [31:0]           mem [DEPTH];

    // Word offset of the latched request relative to the base of the array.
    assign offset_c   = addr_q - BASE_WADDR;
    assign in_range_c = (offset_c >> DEPTH_LOG2) == '0;
    assign idx_c      = offset_c[DEPTH_LOG2-1:0];

    // Ready follows rsp_ready while a response is being retired in back-to-back mode.
`ifdef DMEM_BACK2BACK_EN
    assign req_ready = (state_q == S_RESP) ? rsp_ready : req_ready_q;
`else
    assign req_ready = req_ready_q;
`endif

    assign accept_c  = req_valid & req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // State and response registers; the memory array is deliberately not reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            mask_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic: accept, count down the latency, commit, hold until retired.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (accept_c) begin
                    wen_d       = req_wen;
                    addr_d      = req_addr;
                    mask_d      = req_mask;
                    wdata_d     = req_wdata;
                    cnt_d       = CNT_LOAD;
                    req_ready_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    // Commit edge: the access takes effect and the response is loaded.
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ~in_range_c;
                    rsp_rdata_d = (!wen_q && in_range_c) ? mem[idx_c] : 32'h0;
                    mem_we_c    = wen_q & in_range_c;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
`ifdef DMEM_BACK2BACK_EN
                    if (req_valid) begin
                        wen_d       = req_wen;
                        addr_d      = req_addr;
                        mask_d      = req_mask;
                        wdata_d     = req_wdata;
                        cnt_d       = CNT_LOAD;
                        req_ready_d = 1'b0;
                        state_d     = S_WAIT;
                    end
`endif
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Byte-masked write into the array on the commit edge.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25070198_dmem_resp.sv
// Bench for ysyx_25070198_dmem_resp: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the responder.
module tb_ysyx_25070198_dmem_resp;

    localparam int unsigned DLOG = 10;
    localparam int unsigned LAT  = 2;
    localparam logic [29:0] BASE = 30'h20000000;
`ifdef DMEM_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [29:0] req_addr = '0;
    logic [3:0]  req_mask = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    ysyx_25070198_dmem_resp #(
        .DEPTH_LOG2(DLOG),
        .LATENCY   (LAT),
        .BASE_WADDR(BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen  (req_wen),
        .req_addr (req_addr),
        .req_mask (req_mask),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Edge count and "one edge seen since reset release" flag.
    int cyc   = 0;
    bit armed = 1'b0;
    always @(posedge clk) begin
        cyc++;
        armed <= rst;
    end

    // Transaction-level model: one outstanding request, response due LAT edges after acceptance.
    logic [31:0] m_mem   [1 << DLOG];
    bit          m_known [1 << DLOG];
    bit          m_pend = 1'b0;
    bit          m_applied = 1'b0;
    int          m_due = 0;
    bit          m_wen, m_inr, m_rd_known;
    int          m_off;
    logic [3:0]  m_mask;
    logic [31:0] m_wdata, m_rd;
    logic [29:0] m_offv;
    bit          exp_valid, exp_rdy;

    always @(negedge clk) begin
        if (!rst) begin
            chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("reset_rsp_rdata", rsp_rdata, 32'h0);
            chk("reset_rsp_err",   32'(rsp_err), 32'h0);
            chk("reset_req_ready", 32'(req_ready), 32'h0);
            m_pend = 1'b0;
        end else begin
            exp_valid = m_pend && (cyc >= m_due);
            if (exp_valid && !m_applied) begin
                m_applied = 1'b1;
                if (m_wen && m_inr) begin
                    for (int b = 0; b < 4; b++)
                        if (m_mask[b]) m_mem[m_off][8*b +: 8] = m_wdata[8*b +: 8];
                    if (m_mask == 4'hF) m_known[m_off] = 1'b1;
                end
            end
            exp_rdy = armed && (!m_pend || (B2B && exp_valid && rsp_ready));
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("rsp_err", 32'(rsp_err), 32'(!m_inr));
                if (m_rd_known) chk("rsp_rdata", rsp_rdata, m_rd);
            end
            if (exp_valid && rsp_ready) m_pend = 1'b0;
            if (req_valid && exp_rdy) begin
                m_pend    = 1'b1;
                m_applied = 1'b0;
                m_due     = cyc + 1 + int'(LAT);
                m_wen     = req_wen;
                m_mask    = req_mask;
                m_wdata   = req_wdata;
                m_offv    = req_addr - BASE;
                m_inr     = m_offv < 30'(1 << DLOG);
                m_off     = m_inr ? int'(m_offv) : 0;
                m_rd      = (!m_wen && m_inr) ? m_mem[m_off] : 32'h0;
                m_rd_known = m_wen || !m_inr || m_known[m_off];
            end
        end
    end

    // One full transaction; lat counts edges from the accepting edge to rsp_valid.
    task automatic txn(input logic wen, input logic [29:0] addr, input logic [3:0] mask,
                       input logic [31:0] wdata, input int hold,
                       output logic [31:0] rd, output logic err, output int lat);
        int k;
        rd  = '0;
        err = 1'b0;
        lat = -1;
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_mask  = mask;
        req_wdata = wdata;
        rsp_ready = (hold == 0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ready && k < 50);
        if (!req_ready) begin
            bound_fail("accept");
            req_valid = 1'b0;
            rsp_ready = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!rsp_valid && k < 50);
        if (!rsp_valid) begin
            bound_fail("response");
            rsp_ready = 1'b0;
            return;
        end
        lat = k;
        rd  = rsp_rdata;
        err = rsp_err;
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
            end
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t [4];
        int nrsp, nacc;
        bit acc;
        logic [29:0] a;

        // Reset held for three edges, released just after an edge.
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_first_edge", 32'(req_ready), 32'h1);

        // Full write, then read back.
        txn(1'b1, 30'h20000004, 4'hF, 32'hDEADBEEF, 0, rd, er, lat);
        chk("write_latency", 32'(lat), 32'd2);
        chk("write_err", 32'(er), 32'h0);
        chk("write_rdata", rd, 32'h0);
        txn(1'b0, 30'h20000004, 4'h0, 32'h0, 0, rd, er, lat);
        chk("read_back", rd, 32'hDEADBEEF);
        chk("read_latency", 32'(lat), 32'd2);

        // Single-byte write merges into the stored word.
        txn(1'b1, 30'h20000004, 4'b0100, 32'h00AA0000, 0, rd, er, lat);
        txn(1'b0, 30'h20000004, 4'h0, 32'h0, 0, rd, er, lat);
        chk("byte_merge", rd, 32'hDEAABEEF);

        // Out-of-range on both sides; a write there must not alias word 0.
        txn(1'b1, BASE, 4'hF, 32'h11223344, 0, rd, er, lat);
        txn(1'b0, 30'h1FFFFFFF, 4'h0, 32'h0, 0, rd, er, lat);
        chk("oor_low_err", 32'(er), 32'h1);
        chk("oor_low_rdata", rd, 32'h0);
        txn(1'b0, BASE + 30'd1024, 4'h0, 32'h0, 0, rd, er, lat);
        chk("oor_high_err", 32'(er), 32'h1);
        chk("oor_high_rdata", rd, 32'h0);
        txn(1'b1, BASE + 30'd1024, 4'hF, 32'h55555555, 0, rd, er, lat);
        chk("oor_write_err", 32'(er), 32'h1);
        txn(1'b0, BASE, 4'h0, 32'h0, 0, rd, er, lat);
        chk("oor_no_alias", rd, 32'h11223344);

        // Backpressure: response held for five cycles.
        txn(1'b0, 30'h20000004, 4'h0, 32'h0, 5, rd, er, lat);
        chk("backpressure_rdata", rd, 32'hDEAABEEF);

        // Reset in the middle of a write's wait: the write is dropped.
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 30'h20000004;
        req_mask = 4'hF; req_wdata = 32'hCAFEF00D;
        nacc = 0;
        do begin
            @(negedge clk);
            nacc++;
        end while (!req_ready && nacc < 50);
        if (!req_ready) bound_fail("accept_before_reset");
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1 chk("reset_drops_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 30'h20000004, 4'h0, 32'h0, 0, rd, er, lat);
        chk("reset_discards_write", rd, 32'hDEAABEEF);

        // Streaming: four reads with request and response always ready.
        req_valid = 1'b1; req_wen = 1'b0; req_addr = BASE; req_mask = 4'h0;
        rsp_ready = 1'b1;
        nrsp = 0;
        nacc = 0;
        for (int c = 0; c < 80 && nrsp < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                t[nrsp] = c;
                nrsp++;
            end
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc == 4) req_valid = 1'b0;
                else req_addr = BASE + 30'(nacc);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        if (nrsp < 4) bound_fail("stream_responses");
        else
            for (int i = 1; i < 4; i++)
                chk("stream_interval", 32'(t[i] - t[i-1]), B2B ? 32'(LAT + 1) : 32'(LAT + 2));

        // Randomized traffic over a small window plus some out-of-range addresses.
        for (int n = 0; n < 200; n++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = BASE - 30'(1 + $urandom_range(0, 7));
            else if (sel == 1) a = BASE + 30'(1024 + $urandom_range(0, 7));
            else               a = BASE + 30'($urandom_range(0, 15));
            txn(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                int'($urandom_range(0, 3)), rd, er, lat);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
